// File: rtl/seg_rx.sv
// rtl/seg_rx.sv - seven-segment bus receiver that rebuilds multi-digit hex frames
// Optional feature macro: SEG_RX_DP_EN (capture the dp bit into frame_dp).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   seg_in[7:0]      active-low segments a..g (bits 0..6), dp (bit 7)
//   dig_en_n         active-low digit enables, one low bit per valid scan slot
//   frame_data       decoded nibbles, digit i at [4i+3:4i]
//   frame_dp         decoded dp per digit
//   frame_err        per digit: pattern is not a hex glyph
//   frame_blank      per digit: all segments off
//   frame_valid      frame available
//   frame_ready      consumer accepts the frame
//   overrun          sticky: a frame completed while the previous one was pending
module seg_rx #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            seg_in,
   input  logic [DIGITS-1:0]     dig_en_n,
   output logic [4*DIGITS-1:0]   frame_data,
   output logic [DIGITS-1:0]     frame_dp,
   output logic [DIGITS-1:0]     frame_err,
   output logic [DIGITS-1:0]     frame_blank,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic                  overrun
);

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

   logic [7:0]          seg_pin;
   logic [7:0]          seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_p_q, seg_p_d;
   logic [DIGITS-1:0]   en_s1_q, en_s1_d, en_s2_q, en_s2_d, en_p_q, en_p_d;
   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [DIGITS-1:0]   mask_q, mask_d;
   logic [4*DIGITS-1:0] sh_data_q, sh_data_d, frame_data_q, frame_data_d;
   logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, frame_dp_q, frame_dp_d;
   logic [DIGITS-1:0]   sh_err_q, sh_err_d, frame_err_q, frame_err_d;
   logic [DIGITS-1:0]   sh_blank_q, sh_blank_d, frame_blank_q, frame_blank_d;
   logic                valid_q, valid_d, overrun_q, overrun_d;

   logic [DIGITS-1:0]   en_act;
   logic                en_ok, changed, capture, frame_done, accept;
   logic [6:0]          lit;
   logic [3:0]          dec_nib;
   logic                dec_err, dec_blank, dec_dp;

`ifdef SEG_RX_DP_EN
   assign seg_pin = seg_in;
`else
   // dp forced high so it never disturbs stability detection or capture
   assign seg_pin = {seg_in[7] | 1'b1, seg_in[6:0]};
`endif

   // Synchronizer and previous-sample registers
   always_comb begin
      seg_s1_d = seg_pin;
      seg_s2_d = seg_s1_q;
      seg_p_d  = seg_s2_q;
      en_s1_d  = dig_en_n;
      en_s2_d  = en_s1_q;
      en_p_d   = en_s2_q;
   end

   assign en_act  = ~en_s2_q;
   assign en_ok   = (en_act != '0) && ((en_act & (en_act - DIGITS'(1))) == '0);
   assign changed = (seg_s2_q != seg_p_q) || (en_s2_q != en_p_q);

   // Glyph decode of the lit segments
   assign lit = ~seg_s2_q[6:0];
   always_comb begin
      dec_nib   = 4'h0;
      dec_err   = 1'b0;
      dec_blank = 1'b0;
      dec_dp    = ~seg_s2_q[7];
      case (lit)
         7'h3F: dec_nib = 4'h0;
         7'h06: dec_nib = 4'h1;
         7'h5B: dec_nib = 4'h2;
         7'h4F: dec_nib = 4'h3;
         7'h66: dec_nib = 4'h4;
         7'h6D: dec_nib = 4'h5;
         7'h7D: dec_nib = 4'h6;
         7'h07: dec_nib = 4'h7;
         7'h7F: dec_nib = 4'h8;
         7'h6F: dec_nib = 4'h9;
         7'h77: dec_nib = 4'hA;
         7'h7C: dec_nib = 4'hB;
         7'h39: dec_nib = 4'hC;
         7'h5E: dec_nib = 4'hD;
         7'h79: dec_nib = 4'hE;
         7'h71: dec_nib = 4'hF;
         7'h00: dec_blank = 1'b1;
         default: dec_err = 1'b1;
      endcase
   end

   // Scan FSM: next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (changed) begin
         cnt_d   = 8'd0;
         state_d = en_ok ? SETTLE : IDLE;
      end else begin
         case (state_q)
            IDLE:    cnt_d = 8'd0;
            SETTLE:  if (cnt_q == LAST_CNT) state_d = HELD;
                     else                   cnt_d = cnt_q + 8'd1;
            default: ;
         endcase
      end
   end

   // Scan FSM: outputs
   always_comb begin
      capture = (state_q == SETTLE) && !changed && (cnt_q == LAST_CNT);
   end

   // Shadow slots, slot-seen mask and frame handshake
   assign frame_done = &mask_q;
   assign accept     = valid_q && frame_ready;

   always_comb begin
      mask_d        = frame_done ? '0 : mask_q;
      sh_data_d     = sh_data_q;
      sh_dp_d       = sh_dp_q;
      sh_err_d      = sh_err_q;
      sh_blank_d    = sh_blank_q;
      frame_data_d  = frame_data_q;
      frame_dp_d    = frame_dp_q;
      frame_err_d   = frame_err_q;
      frame_blank_d = frame_blank_q;
      valid_d       = valid_q;
      overrun_d     = overrun_q;

      if (capture) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (en_act[i]) begin
               sh_data_d[4*i +: 4] = dec_nib;
               sh_dp_d[i]          = dec_dp;
               sh_err_d[i]         = dec_err;
               sh_blank_d[i]       = dec_blank;
               mask_d[i]           = 1'b1;
            end
         end
      end

      if (frame_done) begin
         if (valid_q && !frame_ready) begin
            overrun_d = 1'b1;      // pending frame kept, new one dropped
         end else begin
            frame_data_d  = sh_data_q;
            frame_dp_d    = sh_dp_q;
            frame_err_d   = sh_err_q;
            frame_blank_d = sh_blank_q;
            valid_d       = 1'b1;
            if (accept) overrun_d = 1'b0;
         end
      end else if (accept) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1_q      <= '1;
         seg_s2_q      <= '1;
         seg_p_q       <= '1;
         en_s1_q       <= '1;
         en_s2_q       <= '1;
         en_p_q        <= '1;
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         mask_q        <= '0;
         sh_data_q     <= '0;
         sh_dp_q       <= '0;
         sh_err_q      <= '0;
         sh_blank_q    <= '0;
         frame_data_q  <= '0;
         frame_dp_q    <= '0;
         frame_err_q   <= '0;
         frame_blank_q <= '0;
         valid_q       <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         seg_s1_q      <= seg_s1_d;
         seg_s2_q      <= seg_s2_d;
         seg_p_q       <= seg_p_d;
         en_s1_q       <= en_s1_d;
         en_s2_q       <= en_s2_d;
         en_p_q        <= en_p_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mask_q        <= mask_d;
         sh_data_q     <= sh_data_d;
         sh_dp_q       <= sh_dp_d;
         sh_err_q      <= sh_err_d;
         sh_blank_q    <= sh_blank_d;
         frame_data_q  <= frame_data_d;
         frame_dp_q    <= frame_dp_d;
         frame_err_q   <= frame_err_d;
         frame_blank_q <= frame_blank_d;
         valid_q       <= valid_d;
         overrun_q     <= overrun_d;
      end
   end

   assign frame_data  = frame_data_q;
   assign frame_dp    = frame_dp_q;
   assign frame_err   = frame_err_q;
   assign frame_blank = frame_blank_q;
   assign frame_valid = valid_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg_rx.sv
// tb/tb_seg_rx.sv - directed self-checking bench for seg_rx
module tb_seg_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  seg_in;
   logic [3:0]  dig_en_n;
   logic [15:0] frame_data;
   logic [3:0]  frame_dp, frame_err, frame_blank;
   logic        frame_valid, frame_ready, overrun;

   int passed = 0;
   int total  = 0;

   int          acc_cnt = 0;
   int          vcycles = 0;
   logic [15:0] acc_data  = '0;
   logic [3:0]  acc_err   = '0;
   logic [3:0]  acc_blank = '0;
   logic [3:0]  acc_dp    = '0;

   seg_rx #(.DIGITS(4), .STABLE_CYCLES(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .dig_en_n    (dig_en_n),
      .frame_data  (frame_data),
      .frame_dp    (frame_dp),
      .frame_err   (frame_err),
      .frame_blank (frame_blank),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   // Sample mid-low-phase: inputs are driven at negedge, flops update at posedge
   always @(negedge clk) begin
      #1;
      if (frame_valid) vcycles++;
      if (frame_valid && frame_ready) begin
         acc_cnt++;
         acc_data  = frame_data;
         acc_err   = frame_err;
         acc_blank = frame_blank;
         acc_dp    = frame_dp;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic drive_digit(input int idx, input logic [7:0] v, input int n);
      dig_en_n = ~(4'b0001 << idx);
      seg_in   = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      dig_en_n = 4'hF;
      seg_in   = 8'hFF;
      repeat (n) @(negedge clk);
   endtask

   // Digit i takes byte i of v
   task automatic scan(input logic [31:0] v);
      for (int i = 0; i < 4; i++) drive_digit(i, v[8*i +: 8], 12);
   endtask

   int a0, v0;

   initial begin
      rst_n       = 1'b0;
      seg_in      = 8'hFF;
      dig_en_n    = 4'hF;
      frame_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      #2;
      check("rst_valid", frame_valid, 0);
      check("rst_data", frame_data, 0);
      check("rst_dp", frame_dp, 0);
      check("rst_err", frame_err, 0);
      check("rst_blank", frame_blank, 0);
      check("rst_overrun", overrun, 0);
      check("rst_no_accept", acc_cnt, 0);
      @(negedge clk);

      // Plain scan 0,1,2,F
      a0 = acc_cnt; v0 = vcycles;
      scan(32'h8E_A4_F9_C0);
      idle(4);
      check("scan1_accepts", acc_cnt - a0, 1);
      check("scan1_pulse", vcycles - v0, 1);
      check("scan1_data", acc_data, 16'hF210);
      check("scan1_err", acc_err, 4'h0);
      check("scan1_blank", acc_blank, 4'h0);
      check("scan1_valid_low", frame_valid, 0);

      // Invalid glyph on digit 2, blank on digit 3
      scan(32'hFF_FE_88_88);
      idle(4);
      check("errblk_data", acc_data, 16'h00AA);
      check("errblk_err", acc_err, 4'b0100);
      check("errblk_blank", acc_blank, 4'b1000);

      // '0' with dp on for digit 0; default build ignores dp
      scan(32'hC0_C0_C0_40);
      idle(4);
      check("dp_data", acc_data, 16'h0000);
      check("dp_bit", acc_dp, 4'b0000);
      check("dp_err", acc_err, 4'b0000);

      // Two scans without ready
      frame_ready = 1'b0;
      a0 = acc_cnt;
      scan(32'h8E_A4_F9_C0);
      scan(32'hFF_FE_88_88);
      idle(3);
      check("ovr_valid", frame_valid, 1);
      check("ovr_held_data", frame_data, 16'hF210);
      check("ovr_flag", overrun, 1);
      frame_ready = 1'b1;
      @(negedge clk);
      frame_ready = 1'b0;
      idle(2);
      check("ovr_accepts", acc_cnt - a0, 1);
      check("ovr_acc_data", acc_data, 16'hF210);
      check("ovr_valid_low", frame_valid, 0);
      check("ovr_cleared", overrun, 0);
      frame_ready = 1'b1;

      // Short glitch on digit 1 must not be captured
      drive_digit(0, 8'hC0, 12);
      drive_digit(1, 8'hF9, 12);
      drive_digit(1, 8'hA4, 5);
      drive_digit(1, 8'hF9, 5);
      drive_digit(2, 8'hB0, 12);
      drive_digit(3, 8'h99, 12);
      idle(4);
      check("glitch_data", acc_data, 16'h4310);
      check("glitch_err", acc_err, 4'h0);

      // Reset mid-scan discards partial captures
      a0 = acc_cnt;
      drive_digit(0, 8'hC0, 12);
      drive_digit(1, 8'hF9, 12);
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      drive_digit(2, 8'hB0, 12);
      drive_digit(3, 8'h99, 12);
      idle(5);
      check("midrst_no_frame", acc_cnt - a0, 0);
      check("midrst_valid", frame_valid, 0);
      check("midrst_data", frame_data, 16'h0000);
      scan(32'h99_B0_F9_C0);
      idle(4);
      check("postrst_accepts", acc_cnt - a0, 1);
      check("postrst_data", acc_data, 16'h4310);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seg_rx.md
# seg_rx

Seven-segment display receiver: monitors a multiplexed, active-low segment bus plus digit enables, and decodes each digit's pattern back to its hex nibble. It is the reverse of the counter-to-segment encoder. It sits between the display pins, looped back or probed, and the self-check and readback logic. It publishes a complete multi-digit frame through a valid/ready handshake.

## Interface
- DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 8, consecutive identical synchronized samples required before capture (2..255)

- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg_in  input  8  active-low segments; bit0..6 = a..g, bit7 = dp
- dig_en_n  input  DIGITS  active-low digit enables; exactly one low = valid scan slot
- frame_data  output  4*DIGITS  decoded nibbles; digit i at bits [4i+3:4i]
- frame_dp  output  DIGITS  decoded dp per digit
- frame_err  output  DIGITS  per digit: pattern was not one of the 16 hex glyphs
- frame_blank  output  DIGITS  per digit: all segments off (seg_in[6:0] = 7'h7F)
- frame_valid  output  1  frame available
- frame_ready  input  1  consumer accepts frame
- overrun  output  1  sticky: a frame completed while the previous one was still unaccepted

## Operation
- seg_in and dig_en_n pass through a 2-flop synchronizer, giving sample S.
- Scan FSM:
  - IDLE: dig_en_n in S is all-high or has more than one bit low. Counter is held at 0.
  - SETTLE: counting identical samples.
  - HELD: captured; waits for S to change.
- Transitions:
  - Any change in S → SETTLE with cnt=0, or IDLE if the enables are invalid.
  - SETTLE with cnt = STABLE_CYCLES-1 → capture into slot i and move to HELD.
- Exactly one capture occurs per stable period. Counter width is 8 bits and never wraps: it stops counting in HELD.
- Decode of seg_in[6:0], inverted, uses the glyph set 0x3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 → 0..F.
  - Match: nibble written, err=0, blank=0.
  - 0x00: nibble=0, blank=1, err=0.
  - Any other value: nibble=0, err=1, blank=0.
- Slot-seen mask: set bit i on capture. When all DIGITS bits are set, the frame is complete:
  - Shadow slots copy to the frame_* outputs and frame_valid is set.
  - The mask clears.
  - Captures continue into the shadow slots.
- Handshake:
  - frame_valid stays high and frame_* stay stable until a cycle with frame_valid && frame_ready.
  - frame_valid drops the next cycle unless a new frame completes in that same cycle. In that case the new frame loads and frame_valid stays high.
- Frame completes while frame_valid=1 and frame_ready=0: the new frame is discarded, outputs are unchanged, and overrun sets.
- overrun clears only on an accepted handshake that does not itself coincide with a further overrun.
- A repeated capture of the same slot before the frame completes overwrites that shadow slot.

## Timing
- Reset (asynchronous, rst_n low) drives the following:
  - All outputs: frame_data=0, frame_dp=0, frame_err=0, frame_blank=0, frame_valid=0, overrun=0.
  - FSM to IDLE, mask=0, synchronizers to all-ones.
- Latency: a pin change that holds steady updates its shadow slot on the (STABLE_CYCLES+2)th rising edge after the edge on which it is first present. That is edge 10 for the default.
- frame_valid rises one edge after the capture that completes the mask.
- Reset mid-SETTLE or mid-frame discards partial captures. No frame is emitted.
- Glitch: a change shorter than STABLE_CYCLES samples yields no capture and returns the FSM to SETTLE.

## Configuration
- SEG_RX_DP_EN defined: bit7 is captured into frame_dp, active-low (bit7=0 → dp=1).
- SEG_RX_DP_EN undefined: bit7 is ignored for capture and stability, and frame_dp is tied to 0.
- Glyph matching uses bits 6:0 only in both builds.

## Test plan
- Reset release with dig_en_n=4'hF and seg_in=8'hFF held for 100 cycles → frame_valid=0, all outputs 0.
- Scan digits 0..3 with seg_in 8'hC0, F9, A4, 8E, each held for 12 cycles, frame_ready=1 → frame_data=16'hF210, frame_err=0, frame_valid pulses 1 cycle.
- Digit 2 with 8'hFE (invalid) and digit 3 with 8'hFF, others with 8'h88 → frame_data=16'h00AA (digits 2 and 3 = 0), frame_err=4'b0100, frame_blank=4'b1000.
- Digit 0 with seg_in 8'h40, i.e. '0' with dp on, built with and without SEG_RX_DP_EN → frame_dp[0]=1 with the macro, 0 without; nibble 0 in both builds.
- frame_ready=0 for two complete scans → first frame held, overrun=1. Then frame_ready=1 for one cycle → frame accepted, overrun=0.
- Glitch: digit 1 steady at 8'hF9, change to 8'hA4 for 5 cycles, then back to 8'hF9 → slot 1 stays 1, no capture of 2. Also assert rst_n low mid-scan → frame_valid stays 0 after release until a full new scan.
